regfile_access_ctrl: RTL and testbench

//  Command sequencer sitting directly upstream of Register_File: takes burst read/write

---
 rtl/regfile_access_ctrl_if.sv | 36 +++
 rtl/regfile_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_access_ctrl_if.sv
// Command/write-data/response streams plus the Register_File port bundle for regfile_access_ctrl.
interface regfile_access_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic                  verify_err;
  logic                  RF_WrEn;
  logic                  RF_RdEn;
  logic [ADDR_WIDTH-1:0] RF_Address;
  logic [DATA_WIDTH-1:0] RF_WrData;
  logic [DATA_WIDTH-1:0] RF_RdData;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rsp_ready, RF_RdData,
    output cmd_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, verify_err,
           RF_WrEn, RF_RdEn, RF_Address, RF_WrData
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rsp_ready, RF_RdData,
    input  cmd_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, verify_err,
           RF_WrEn, RF_RdEn, RF_Address, RF_WrData
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Burst command sequencer in front of Register_File; one command in flight, all outputs registered.
// Optional READBACK_VERIFY_EN: read back every written beat and flag mismatches.
module regfile_access_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  regfile_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WR_ACCEPT, WR_ISSUE, RD_ISSUE, RD_CAPTURE, RESP, VF_ISSUE, VF_CAPTURE
  } state_t;

  state_t                state;
  logic                  isWrite;
  logic [ADDR_WIDTH-1:0] curAddr;
  logic [ADDR_WIDTH-1:0] beatsLeft;
  logic [ADDR_WIDTH:0]   beatCnt;
  logic                  cmdErr;
  logic                  beatErr;
  logic [DATA_WIDTH-1:0] ackWord;

`ifdef READBACK_VERIFY_EN
  // RF_WrData still holds the beat just written while its readback is captured.
  assign beatErr = (bus.RF_RdData != bus.RF_WrData);
`else
  assign beatErr = 1'b0;
`endif

  always_comb begin
    ackWord                 = '0;
    ackWord[ADDR_WIDTH:0]   = beatCnt;
    ackWord[DATA_WIDTH-1]   = cmdErr | beatErr;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= IDLE;
      isWrite         <= 1'b0;
      curAddr         <= '0;
      beatsLeft       <= '0;
      beatCnt         <= '0;
      cmdErr          <= 1'b0;
      bus.cmd_ready   <= 1'b1;
      bus.wdata_ready <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_last    <= 1'b0;
      bus.verify_err  <= 1'b0;
      bus.RF_WrEn     <= 1'b0;
      bus.RF_RdEn     <= 1'b0;
      bus.RF_Address  <= '0;
      bus.RF_WrData   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          isWrite       <= bus.cmd_write;
          curAddr       <= bus.cmd_addr;
          beatsLeft     <= bus.cmd_len;
          beatCnt       <= '0;
          cmdErr        <= 1'b0;
          bus.cmd_ready <= 1'b0;
          if (bus.cmd_write) begin
            bus.wdata_ready <= 1'b1;
            state           <= WR_ACCEPT;
          end else begin
            bus.RF_RdEn    <= 1'b1;
            bus.RF_Address <= bus.cmd_addr;
            state          <= RD_ISSUE;
          end
        end
        WR_ACCEPT: if (bus.wdata_valid) begin
          bus.wdata_ready <= 1'b0;
          bus.RF_WrData   <= bus.wdata;
          bus.RF_Address  <= curAddr;
          bus.RF_WrEn     <= 1'b1;
          beatCnt         <= beatCnt + 1'b1;
          state           <= WR_ISSUE;
        end
`ifdef READBACK_VERIFY_EN
        WR_ISSUE: begin
          bus.RF_WrEn <= 1'b0;
          bus.RF_RdEn <= 1'b1;
          state       <= VF_ISSUE;
        end
        VF_ISSUE: begin
          bus.RF_RdEn <= 1'b0;
          state       <= VF_CAPTURE;
        end
        VF_CAPTURE: begin
          if (beatErr) begin
            bus.verify_err <= 1'b1;
            cmdErr         <= 1'b1;
          end
`else
        WR_ISSUE: begin
          bus.RF_WrEn <= 1'b0;
`endif
          if (beatsLeft != '0) begin
            beatsLeft       <= beatsLeft - 1'b1;
            curAddr         <= curAddr + 1'b1;
            bus.wdata_ready <= 1'b1;
            state           <= WR_ACCEPT;
          end else begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= ackWord;
            bus.rsp_last  <= 1'b1;
            state         <= RESP;
          end
        end
        RD_ISSUE: begin
          bus.RF_RdEn <= 1'b0;
          state       <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          bus.rsp_data  <= bus.RF_RdData;
          bus.rsp_valid <= 1'b1;
          bus.rsp_last  <= (beatsLeft == '0);
          state         <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_last  <= 1'b0;
          bus.rsp_data  <= '0;
          if (!isWrite && beatsLeft != '0) begin
            beatsLeft      <= beatsLeft - 1'b1;
            curAddr        <= curAddr + 1'b1;
            bus.RF_Address <= curAddr + 1'b1;
            bus.RF_RdEn    <= 1'b1;
            state          <= RD_ISSUE;
          end else begin
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a behavioural Register_File model.
module tb_regfile_access_ctrl;
  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int TMO = 200;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  regfile_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  regfile_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int nVec = 0;
  int nMis = 0;
  exp_t sbQ[$];
  logic [AW-1:0] wrAddrQ[$];
  int wrPulses = 0;
  int rdPulses = 0;
  logic forceZero = 1'b0;
  logic [DW-1:0] wd [8];
  logic [DW-1:0] rd [8];

  // Register_File model: synchronous write, read data valid the cycle after RdEn
  logic [DW-1:0] mem [8];
  always @(posedge CLK) begin
    if (bus.RF_WrEn) mem[bus.RF_Address] <= bus.RF_WrData;
    if (bus.RF_RdEn) bus.RF_RdData <= forceZero ? '0 : mem[bus.RF_Address];
  end

  // Monitor: pops the scoreboard on every response handshake
  always @(negedge CLK) if (RST) begin
    if (bus.RF_WrEn) begin wrPulses++; wrAddrQ.push_back(bus.RF_Address); end
    if (bus.RF_RdEn) rdPulses++;
    if (bus.RF_WrEn && bus.RF_RdEn) begin
      nVec++; nMis++;
      $display("FAIL wr_rd_exclusive: both enables high at %0t", $time);
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      nVec++;
      if (sbQ.size() == 0) begin
        nMis++;
        $display("FAIL unexpected_rsp: data=%h last=%b with empty scoreboard", bus.rsp_data, bus.rsp_last);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        if (bus.rsp_data !== e.data || bus.rsp_last !== e.last) begin
          nMis++;
          $display("FAIL rsp: got data=%h last=%b, expected data=%h last=%b",
                   bus.rsp_data, bus.rsp_last, e.data, e.last);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string what);
    nVec++; nMis++;
    $display("FAIL timeout_%s: no progress within %0d cycles", what, TMO);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic issueCmd(input logic w, input logic [AW-1:0] addr, input logic [AW-1:0] len);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = addr; bus.cmd_len = len;
    do begin @(negedge CLK); n++; end while (!bus.cmd_ready && n < TMO);
    if (!bus.cmd_ready) timeout("cmd");
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic sendBeat(input logic [DW-1:0] d, input int gap);
    int n = 0;
    repeat (gap) tick();
    bus.wdata_valid = 1'b1; bus.wdata = d;
    do begin @(negedge CLK); n++; end while (!bus.wdata_ready && n < TMO);
    if (!bus.wdata_ready) timeout("wdata");
    tick();
    bus.wdata_valid = 1'b0;
  endtask

  // Sends nSend beats from wd[]; the ack is only expected for a complete burst
  task automatic doWrite(input logic [AW-1:0] addr, input logic [AW-1:0] len, input int gap,
                         input int nSend, input logic [DW-1:0] ack);
    if (nSend == int'(len) + 1) sbQ.push_back('{data: ack, last: 1'b1});
    issueCmd(1'b1, addr, len);
    for (int i = 0; i < nSend; i++) sendBeat(wd[i], gap);
  endtask

  task automatic doRead(input logic [AW-1:0] addr, input logic [AW-1:0] len);
    for (int i = 0; i <= int'(len); i++) sbQ.push_back('{data: rd[i], last: (i == int'(len))});
    issueCmd(1'b0, addr, len);
  endtask

  task automatic drain();
    int n = 0;
    do begin @(negedge CLK); n++; end while ((sbQ.size() != 0 || !bus.cmd_ready) && n < TMO);
    if (sbQ.size() != 0 || !bus.cmd_ready) timeout("drain");
    tick();
  endtask

  initial begin
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wdata_valid = 0; bus.wdata = '0; bus.rsp_ready = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_flags", {bus.cmd_ready, bus.wdata_ready, bus.rsp_valid, bus.rsp_last,
                          bus.verify_err, bus.RF_WrEn, bus.RF_RdEn}, 7'b1000000);
    check("reset_rf_bus", {bus.RF_Address, bus.RF_WrData, bus.rsp_data}, '0);
    tick(); RST = 1'b1; tick();

    // Reset in the middle of a 4-beat write, right after beat 2 is issued
    wd[0] = 16'h1111; wd[1] = 16'h2222;
    doWrite(3'd0, 3'd3, 0, 2, '0);
    RST = 1'b0;
    @(negedge CLK);
    check("midburst_reset_flags", {bus.cmd_ready, bus.wdata_ready, bus.rsp_valid,
                                   bus.RF_WrEn, bus.RF_RdEn}, 5'b10000);
    check("midburst_reset_rf", {bus.RF_Address, bus.RF_WrData}, '0);
    tick(); RST = 1'b1; tick();

    // Single write then read at address 2
    wrAddrQ.delete();
    wd[0] = 16'h0025;
    doWrite(3'd2, 3'd0, 0, 1, 16'h0001);
    drain();
    check("single_wr_addr", {wrAddrQ.size(), 3'(wrAddrQ[0])}, {32'd1, 3'd2});
    rd[0] = 16'h0025;
    doRead(3'd2, 3'd0);
    drain();

    // Address wrap 6,7,0,1
    wrAddrQ.delete();
    wd[0] = 16'h0011; wd[1] = 16'h0022; wd[2] = 16'h0033; wd[3] = 16'h0044;
    doWrite(3'd6, 3'd3, 0, 4, 16'h0004);
    drain();
    check("wrap_wr_count", wrAddrQ.size(), 4);
    if (wrAddrQ.size() == 4)
      check("wrap_wr_addrs", {wrAddrQ[0], wrAddrQ[1], wrAddrQ[2], wrAddrQ[3]},
            {3'd6, 3'd7, 3'd0, 3'd1});
    rd[0] = 16'h0011; rd[1] = 16'h0022; rd[2] = 16'h0033; rd[3] = 16'h0044;
    doRead(3'd6, 3'd3);
    drain();

    // Backpressure on a 2-beat read at address 5
    begin
      int r0, n;
      wd[0] = 16'h0A5A; wd[1] = 16'h0B6B;
      doWrite(3'd5, 3'd1, 0, 2, 16'h0002);
      drain();
      rd[0] = 16'h0A5A; rd[1] = 16'h0B6B;
      bus.rsp_ready = 1'b0;
      r0 = rdPulses;
      doRead(3'd5, 3'd1);
      n = 0;
      do begin @(negedge CLK); n++; end while (!bus.rsp_valid && n < TMO);
      if (!bus.rsp_valid) timeout("bp_valid");
      for (int i = 0; i < 10; i++) begin
        check("bp_hold", {bus.rsp_valid, bus.rsp_data, bus.rsp_last, 8'(rdPulses - r0)},
              {1'b1, 16'h0A5A, 1'b0, 8'd1});
        @(negedge CLK);
      end
      @(posedge CLK); #1 bus.rsp_ready = 1'b1;
      drain();
      check("bp_rden_total", rdPulses - r0, 2);
    end

    // wdata_valid while idle is ignored; then a write with 5-cycle beat gaps
    begin
      int w0;
      w0 = wrPulses;
      bus.wdata_valid = 1'b1; bus.wdata = 16'hDEAD;
      repeat (3) tick();
      bus.wdata_valid = 1'b0;
      tick();
      check("idle_wdata_ignored", {wrPulses - w0, 31'(bus.cmd_ready)}, {32'd0, 31'd1});
      wd[0] = 16'h0C0C; wd[1] = 16'h0D0D;
      doWrite(3'd3, 3'd1, 5, 2, 16'h0002);
      drain();
      check("stall_wren_pulses", wrPulses - w0, 2);
    end

`ifdef READBACK_VERIFY_EN
    forceZero = 1'b1;
    wd[0] = 16'h0194;
    doWrite(3'd4, 3'd0, 0, 1, 16'h8001);
    drain();
    forceZero = 1'b0;
    check("verify_err_set", bus.verify_err, 1'b1);
    wd[0] = 16'h0042;
    doWrite(3'd4, 3'd0, 0, 1, 16'h0001);
    drain();
    check("verify_err_sticky", bus.verify_err, 1'b1);
`else
    forceZero = 1'b1;
    wd[0] = 16'h0194;
    doWrite(3'd4, 3'd0, 0, 1, 16'h0001);
    drain();
    forceZero = 1'b0;
    check("verify_err_off", bus.verify_err, 1'b0);
`endif

    check("scoreboard_empty", sbQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
